// File: rtl/piso_shift_tx_pkg.sv
// ---------------------------------------------------------------------------
// piso_shift_tx_pkg
//   Shared definitions for the parallel-in/serial-out transmitter and its
//   SIPO receiver partner, so both ends agree on word length and state codes.
//   Contents:
//     DEFAULT_WIDTH : default word length in bits (8)
//     state_t       : transmitter FSM state (ST_IDLE / ST_SHIFT)
// ---------------------------------------------------------------------------
package piso_shift_tx_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/piso_shift_tx_if.sv
// ---------------------------------------------------------------------------
// piso_shift_tx_if
//   Bundle of the load handshake, bit-rate enable, abort and serial outputs
//   of the PISO transmitter.
//
//   Handshake: a word moves from source to transmitter only on a rising clock
//   edge where load_valid and load_ready are both high. load_ready does not
//   depend on load_valid. so is consumed on every cycle where so_valid is high
//   (busy & shift_en); there is no back-pressure on the serial side.
//
//   Signals:
//     load_data  [WIDTH] source -> tx  parallel word
//     load_valid         source -> tx  load_data is offered
//     load_ready         tx -> source  transmitter can take a word
//     shift_en           source -> tx  bit-rate enable
//     abort              source -> tx  synchronous flush to idle
//     so                 tx -> link    serial data
//     so_valid           tx -> link    so is consumed this cycle
//     busy               tx -> source  a word is in flight
//     done               tx -> source  one-cycle end-of-word pulse
//   Modports: master (data source / link side), slave (transmitter).
// ---------------------------------------------------------------------------
interface piso_shift_tx_if
    import piso_shift_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             shift_en;
    logic             abort;
    logic             so;
    logic             so_valid;
    logic             busy;
    logic             done;

    modport master (
        output load_data, load_valid, shift_en, abort,
        input  load_ready, so, so_valid, busy, done
    );

    modport slave (
        input  load_data, load_valid, shift_en, abort,
        output load_ready, so, so_valid, busy, done
    );
endinterface

// File: rtl/piso_shift_tx.sv
// ---------------------------------------------------------------------------
// piso_shift_tx
//   Parallel-in, serial-out shift transmitter. Takes a WIDTH-bit word through
//   the load handshake and shifts it out one bit per enabled clock, MSB or
//   LSB first. Reports busy while shifting and pulses done once per finished
//   word.
//   Ports:
//     clock     : system clock, rising edge
//     reset     : asynchronous, active-low
//     bus       : piso_shift_tx_if.slave (handshake, enable, serial outputs)
//     dbg_state : current FSM state for observation
// ---------------------------------------------------------------------------
module piso_shift_tx
    import piso_shift_tx_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic           clock,
    input  logic           reset,
    piso_shift_tx_if.slave bus,
    output state_t         dbg_state
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    bit_cnt, bit_cnt_n;
    logic             done_r, done_n;
    logic             busy;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            done_r  <= 1'b0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_cnt <= bit_cnt_n;
            done_r  <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        done_n    = 1'b0;     // done_r is a pulse: cleared unless set below

        if (bus.abort) begin
            // Flush wins over everything, including a pending load or the
            // final shift edge, so no done pulse is produced.
            state_n   = ST_IDLE;
            shreg_n   = '0;
            bit_cnt_n = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.load_valid) begin
                        state_n   = ST_SHIFT;
                        shreg_n   = bus.load_data;
                        bit_cnt_n = '0;
                    end
                end
                ST_SHIFT: begin
                    if (bus.shift_en) begin
                        // The outgoing bit always sits at one end of shreg;
                        // the vacated position fills with zero.
                        shreg_n = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                        if (bit_cnt == LAST_BIT) begin
                            state_n   = ST_IDLE;
                            bit_cnt_n = '0;
                            done_n    = 1'b1;
                        end else begin
                            bit_cnt_n = bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // All outputs decode from registers (plus shift_en for so_valid), so an
    // asynchronous reset clears them without waiting for a clock edge.
    assign busy           = (state == ST_SHIFT);
    assign bus.busy       = busy;
    assign bus.load_ready = (state == ST_IDLE);
    assign bus.so         = busy ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : 1'b0;
    assign bus.so_valid   = busy & bus.shift_en;
    assign bus.done       = done_r;
    assign dbg_state      = state;

endmodule

// File: tb/tb_piso_shift_tx.sv
// ---------------------------------------------------------------------------
// tb_piso_shift_tx
//   Drives an MSB-first and an LSB-first transmitter with identical stimulus.
//   A queue-based model of the bit stream predicts every output each cycle;
//   directed words pin the model with hand-computed bit sequences.
// ---------------------------------------------------------------------------
module tb_piso_shift_tx;
    import piso_shift_tx_pkg::*;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // ---------------- shared stimulus ----------------
    logic [W-1:0] load_data  = '0;
    logic         load_valid = 1'b0;
    logic         shift_en   = 1'b1;
    logic         abort      = 1'b0;

    piso_shift_tx_if #(.WIDTH(W)) if_m ();
    piso_shift_tx_if #(.WIDTH(W)) if_l ();

    assign if_m.load_data  = load_data;
    assign if_m.load_valid = load_valid;
    assign if_m.shift_en   = shift_en;
    assign if_m.abort      = abort;
    assign if_l.load_data  = load_data;
    assign if_l.load_valid = load_valid;
    assign if_l.shift_en   = shift_en;
    assign if_l.abort      = abort;

    state_t dbg_m, dbg_l;

    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clock(clock), .reset(reset), .bus(if_m), .dbg_state(dbg_m)
    );
    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clock(clock), .reset(reset), .bus(if_l), .dbg_state(dbg_l)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    endtask

    // Model: a word is a queue of bits in transmit order; one bit leaves per
    // enabled cycle while busy; done follows the cycle the queue empties.
    logic [0:0] exp_q_m[$];
    logic [0:0] exp_q_l[$];
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            exp_q_m.delete();
            exp_q_l.delete();
        end else if (abort) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            exp_q_m.delete();
            exp_q_l.delete();
        end else if (!m_busy) begin
            m_done = 1'b0;
            if (load_valid) begin
                m_busy = 1'b1;
                for (int i = 0; i < W; i++) begin
                    exp_q_m.push_back(load_data[W-1-i]);
                    exp_q_l.push_back(load_data[i]);
                end
            end
        end else begin
            m_done = 1'b0;
            if (shift_en) begin
                void'(exp_q_m.pop_front());
                void'(exp_q_l.pop_front());
                if (exp_q_m.size() == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    end

    // Every-cycle compare, mid-period.
    bit chk_en = 1'b0;
    always @(negedge clock) begin
        if (chk_en) begin
            logic exp_so_m, exp_so_l;
            exp_so_m = (m_busy && exp_q_m.size() > 0) ? exp_q_m[0][0] : 1'b0;
            exp_so_l = (m_busy && exp_q_l.size() > 0) ? exp_q_l[0][0] : 1'b0;
            check("ready_m",    32'(if_m.load_ready), 32'(!m_busy));
            check("busy_m",     32'(if_m.busy),       32'(m_busy));
            check("so_valid_m", 32'(if_m.so_valid),   32'(m_busy & shift_en));
            check("done_m",     32'(if_m.done),       32'(m_done));
            check("so_m",       32'(if_m.so),         32'(exp_so_m));
            check("state_m",    32'(dbg_m),           32'(m_busy ? ST_SHIFT : ST_IDLE));
            check("ready_l",    32'(if_l.load_ready), 32'(!m_busy));
            check("busy_l",     32'(if_l.busy),       32'(m_busy));
            check("so_valid_l", 32'(if_l.so_valid),   32'(m_busy & shift_en));
            check("done_l",     32'(if_l.done),       32'(m_done));
            check("so_l",       32'(if_l.so),         32'(exp_so_l));
        end
    end

    // ---------------- driver tasks ----------------
    logic [W-1:0] seq_m, seq_l;
    int           done_cyc, done_cnt;
    logic [15:0]  busy_tr, ready_tr, sov_tr, so_tr;

    // Entered and left at posedge+1. Offers data for one edge (the accept
    // edge), then runs ncyc cycles; bit c of each mask applies to cycle c.
    task automatic send_word(input logic [W-1:0] data, input logic [15:0] stall_mask,
                             input logic [15:0] lv_mask, input logic [15:0] abort_mask,
                             input int ncyc);
        load_data  = data;
        load_valid = 1'b1;
        shift_en   = 1'b1;
        abort      = 1'b0;
        @(posedge clock); #1;
        seq_m = '0; seq_l = '0; done_cyc = 0; done_cnt = 0;
        busy_tr = '0; ready_tr = '0; sov_tr = '0; so_tr = '0;
        for (int c = 1; c <= ncyc; c++) begin
            shift_en   = !stall_mask[c];
            load_valid = lv_mask[c];
            load_data  = lv_mask[c] ? '0 : data;
            abort      = abort_mask[c];
            @(negedge clock);
            if (if_m.so_valid) seq_m = {seq_m[W-2:0], if_m.so};
            if (if_l.so_valid) seq_l = {seq_l[W-2:0], if_l.so};
            if (if_m.done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            busy_tr[c]  = if_m.busy;
            ready_tr[c] = if_m.load_ready;
            sov_tr[c]   = if_m.so_valid;
            so_tr[c]    = if_m.so;
            @(posedge clock); #1;
        end
        load_valid = 1'b0;
        abort      = 1'b0;
        shift_en   = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1 reset = 1'b0;
        #1 chk_en = 1'b1;
        load_valid = 1'b1;       // offered during reset: must not be taken
        load_data  = 8'hAA;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready",    32'(if_m.load_ready), 32'd1);
        check("rst_busy",     32'(if_m.busy),       32'd0);
        check("rst_so_valid", 32'(if_m.so_valid),   32'd0);
        check("rst_done",     32'(if_m.done),       32'd0);
        load_valid = 1'b0;
        reset      = 1'b1;
        @(posedge clock); #1;

        // Plain word, both bit orders
        send_word(8'h1D, 16'h0, 16'h0, 16'h0, 10);
        check("t1_seq_msb",  32'(seq_m), 32'h1D);
        check("t2_seq_lsb",  32'(seq_l), 32'hB8);
        check("t1_done_cyc", done_cyc, 9);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_ready9",   32'(ready_tr[9]), 32'd1);
        check("t1_busy8_1",  32'(busy_tr[8:1]), 32'hFF);

        // Stall on cycles 3..5
        send_word(8'hA5, 16'b0000_0000_0011_1000, 16'h0, 16'h0, 13);
        check("t3_seq_msb",  32'(seq_m), 32'hA5);
        check("t3_seq_lsb",  32'(seq_l), 32'hA5);
        check("t3_done_cyc", done_cyc, 12);
        check("t3_stall_sv", 32'(sov_tr[5:3]), 32'd0);
        check("t3_stall_so", 32'(so_tr[6:3]), 32'hF);  // bit 5 of A5 is 1

        // load_valid with other data while busy, through the final shift edge
        send_word(8'hFF, 16'h0, 16'b0000_0001_1111_1100, 16'h0, 10);
        check("t4_seq_msb",  32'(seq_m), 32'hFF);
        check("t4_ready",    32'(ready_tr[8:1]), 32'd0);
        check("t4_done_cyc", done_cyc, 9);
        check("t4_no_accept",32'(busy_tr[10:9]), 32'd0);

        // Abort in cycle 4
        send_word(8'hF0, 16'h0, 16'h0, 16'b0000_0000_0001_0000, 7);
        check("t5_busy5",    32'(busy_tr[5]),  32'd0);
        check("t5_ready5",   32'(ready_tr[5]), 32'd1);
        check("t5_so5",      32'(so_tr[5]),    32'd0);
        check("t5_done_cnt", done_cnt, 0);
        check("t5_part_msb", 32'(seq_m), 32'h0F);
        check("t5_part_lsb", 32'(seq_l), 32'h00);
        send_word(8'h0F, 16'h0, 16'h0, 16'h0, 10);
        check("t5b_seq_msb", 32'(seq_m), 32'h0F);
        check("t5b_seq_lsb", 32'(seq_l), 32'hF0);
        check("t5b_done_cnt", done_cnt, 1);

        // Asynchronous reset during bit 5
        send_word(8'hC3, 16'h0, 16'h0, 16'h0, 4);
        #2 reset = 1'b0;
        #1;
        check("t6_busy_m",  32'(if_m.busy),     32'd0);
        check("t6_sov_m",   32'(if_m.so_valid), 32'd0);
        check("t6_so_m",    32'(if_m.so),       32'd0);
        check("t6_busy_l",  32'(if_l.busy),     32'd0);
        check("t6_sov_l",   32'(if_l.so_valid), 32'd0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (if_m.done || if_l.done) done_cnt++;
        end
        check("t6_no_done", done_cnt, 0);
        @(posedge clock); #1;
        send_word(8'h81, 16'h0, 16'h0, 16'h0, 10);
        check("t6_seq_msb", 32'(seq_m), 32'h81);
        check("t6_seq_lsb", 32'(seq_l), 32'h81);

        // Randomized traffic checked cycle by cycle against the model
        for (int c = 0; c < 800; c++) begin
            load_valid = 1'($urandom_range(0, 1));
            load_data  = W'($urandom);
            shift_en   = ($urandom_range(0, 3) != 0);
            abort      = ($urandom_range(0, 29) == 0);
            @(posedge clock); #1;
        end
        load_valid = 1'b0;
        abort      = 1'b0;
        repeat (3) @(posedge clock);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
Parallel-in, serial-out shift transmitter. It is the transmit end of the 8-bit serial-in/parallel-out register chain used in this lab series. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts the word out one bit per enabled clock. It reports busy while shifting and pulses done once per completed word. It sits between a parallel data source (switches or a register file) and a serial link whose receiver is the SIPO shift register.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.
MSB_FIRST, 1, 1 = bit WIDTH-1 is transmitted first; 0 = bit 0 first.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low; clock is clock.
abort  input  1  synchronous flush; returns the block to IDLE with no done pulse.
load_data  input  WIDTH  parallel word to transmit.
load_valid  input  1  source offers load_data this cycle.
load_ready  output  1  block can accept a word this cycle.
shift_en  input  1  bit-rate enable; one bit is consumed per cycle in which it is high during SHIFT.
so  output  1  serial data out.
so_valid  output  1  so is being consumed this cycle.
busy  output  1  a word is in flight.
done  output  1  one-cycle pulse after the last bit of a word is consumed.

Behaviour:
- Registers: state (IDLE/SHIFT), shreg[WIDTH-1:0], bit_cnt[$clog2(WIDTH)-1:0], done_r.
- Reset (reset=0, asynchronous): state=IDLE, shreg=0, bit_cnt=0, done_r=0.
  - While in reset: so=0, so_valid=0, busy=0, done=0, load_ready=1.
  - No word is accepted while reset is low.
- Combinational outputs, decoded from registers only:
  - load_ready = (state==IDLE).
  - busy = (state==SHIFT).
  - so = busy ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : 0.
  - so_valid = busy & shift_en.
  - done = done_r.
- Priority per edge: reset > abort > normal operation.
- IDLE:
  - Accept occurs when load_valid & load_ready are both high at the edge.
  - On accept: shreg<=load_data, bit_cnt<=0, state<=SHIFT.
  - The first bit appears on so in the next cycle.
- SHIFT, with shift_en=1 at the edge:
  - MSB_FIRST=1: shreg<=shreg<<1. MSB_FIRST=0: shreg<=shreg>>1. Vacated bit fills with 0.
  - bit_cnt<=bit_cnt+1.
  - If bit_cnt==WIDTH-1: state<=IDLE, done_r<=1, bit_cnt<=0.
- SHIFT, with shift_en=0: stall. shreg, bit_cnt and so hold their values; so_valid=0.
- done_r clears to 0 on every edge where it is not being set, so done is exactly one cycle wide.
- Latency (shift_en held at 1, word accepted at edge N):
  - Bits appear in cycles N+1 .. N+WIDTH.
  - done=1 and load_ready=1 in cycle N+WIDTH+1.
  - Minimum word-to-word period is WIDTH+1 cycles. No accept occurs on the final shift edge.
- load_valid while busy: ignored. load_data may change freely; the word in flight is unaffected.
- abort=1 at an edge:
  - state<=IDLE, bit_cnt<=0, shreg<=0, done_r<=0.
  - A simultaneous load_valid is not accepted.
  - abort while in IDLE has no effect beyond clearing registers.
- abort coinciding with the last shift edge: abort wins; no done pulse.
- Reset mid-shift: the word is discarded immediately; no done pulse after reset releases.
- shift_en while IDLE: ignored.
- A word is accepted only when load_valid and load_ready are both high at a rising edge; no other signal starts a transmission.

Decomposition:
- Shared header/package: state encodings ST_IDLE=1'b0 and ST_SHIFT=1'b1, plus the default WIDTH constant (8), so this block and the SIPO receiver agree on word length.
- No sub-module; the counter and shifter are single-level logic in one module.

Test Plan:
1. Reset released. WIDTH=8, MSB_FIRST=1, shift_en=1. Load 0x1D. -> so = 0,0,0,1,1,1,0,1 in cycles 1..8 with so_valid=1 and busy=1; done=1 and load_ready=1 in cycle 9; done=0 in cycle 10.
2. MSB_FIRST=0, shift_en=1. Load 0x1D. -> so = 1,0,1,1,1,0,0,0; done pulses once in cycle 9.
3. MSB_FIRST=1. Load 0xA5. shift_en low on cycles 3..5, high otherwise. -> so holds its value and so_valid=0 during the stall; all 8 bits are still 1,0,1,0,0,1,0,1; done arrives 3 cycles later than unstalled (cycle 12).
4. Load 0xFF. During cycles 2..7 drive load_valid=1 with load_data=0x00. -> load_ready=0 throughout; all 8 bits are 1; the second word is accepted only in cycle 9 or later.
5. Load 0xF0. Assert abort in cycle 4. -> cycle 5: busy=0, so=0, load_ready=1, no done pulse. Then load 0x0F -> serialises correctly.
6. Load 0xC3. Pull reset low asynchronously mid-cycle during bit 5. -> so, so_valid and busy drop immediately, before the next clock edge; no done pulse after release; the next load 0x81 -> so = 1,0,0,0,0,0,0,1.
